// File: rtl/game_ctrl.sv
// game_ctrl: frame-based collision, scoring and state sequencing for the obstacle game
module game_ctrl #(
  parameter int HIT_FRAMES  = 2,
  parameter int HOLD_FRAMES = 120,
  parameter int SCORE_W     = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ani_stb,
  input  logic               i_start,
  input  logic [11:0]        i_ob_x1,
  input  logic [11:0]        i_ob_x2,
  input  logic [11:0]        i_ob_y1,
  input  logic [11:0]        i_ob_y2,
  input  logic [11:0]        i_pl_x1,
  input  logic [11:0]        i_pl_x2,
  input  logic [11:0]        i_pl_y1,
  input  logic [11:0]        i_pl_y2,
  output logic               o_animate,
  output logic               o_obs_rst,
  output logic [SCORE_W-1:0] o_score,
  output logic [1:0]         o_state,
  output logic               o_hit
);
  typedef enum logic [1:0] {IDLE, RUN, HIT, OVER} state_t;
  state_t state_q, state_d;
  logic start_q, past_q, past_d, obs_rst_q, obs_rst_d, animate_q, animate_d, hit_q, hit_d;
  logic [3:0] hcnt_q, hcnt_d, hcnt_inc;
  logic [7:0] hold_q, hold_d, hold_inc;
  logic [SCORE_W-1:0] score_q, score_d;
  logic start_rise, overlap, past;
  // next-state: start handling in IDLE/OVER, per-strobe scoring/debounce in RUN, hold count in HIT
  always_comb begin
    start_rise = i_start & ~start_q;
    overlap = (i_ob_x1 <= i_pl_x2) & (i_pl_x1 <= i_ob_x2) & (i_ob_y1 <= i_pl_y2) & (i_pl_y1 <= i_ob_y2);
    past = i_ob_x1 > i_pl_x2;
    hcnt_inc = hcnt_q + 4'd1;
    hold_inc = hold_q + 8'd1;
    state_d = state_q;
    past_d = past_q;
    hcnt_d = hcnt_q;
    hold_d = hold_q;
    score_d = score_q;
    obs_rst_d = 1'b0;
    if ((state_q == IDLE || state_q == OVER) && start_rise) begin
      state_d = RUN;
      score_d = '0;
      hcnt_d = '0;
      hold_d = '0;
      past_d = 1'b1;
      obs_rst_d = 1'b1;
    end else if (state_q == RUN && i_ani_stb) begin
      hcnt_d = overlap ? hcnt_inc : 4'd0;
      score_d = (past & ~past_q & ~&score_q) ? score_q + 1'b1 : score_q;
      past_d = past;
      state_d = (overlap && hcnt_inc == 4'(HIT_FRAMES)) ? HIT : RUN;
    end else if (state_q == HIT && i_ani_stb) begin
      hold_d = hold_inc;
      state_d = (hold_inc == 8'(HOLD_FRAMES)) ? OVER : HIT;
    end
    animate_d = (state_d == RUN) & ~obs_rst_d;
    hit_d = state_d == HIT;
  end
  // state, counters and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      past_q <= 1'b1;
      hcnt_q <= '0;
      hold_q <= '0;
      score_q <= '0;
      obs_rst_q <= 1'b0;
      animate_q <= 1'b0;
      hit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= i_start;
      past_q <= past_d;
      hcnt_q <= hcnt_d;
      hold_q <= hold_d;
      score_q <= score_d;
      obs_rst_q <= obs_rst_d;
      animate_q <= animate_d;
      hit_q <= hit_d;
    end
  end
  assign o_animate = animate_q;
  assign o_obs_rst = obs_rst_q;
  assign o_score = score_q;
  assign o_state = state_q;
  assign o_hit = hit_q;
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed checks of start, scoring, debounce, hold, restart, saturation and reset
module tb_game_ctrl;
  logic clk = 1'b0, rst = 1'b1, stb = 1'b0, start = 1'b0;
  logic [11:0] ob_x1, ob_x2, ob_y1, ob_y2;
  logic [11:0] pl_x1 = 12'd100, pl_x2 = 12'd120, pl_y1 = 12'd100, pl_y2 = 12'd120;
  logic animate, obs_rst, hit, animate_s, obs_rst_s, hit_s;
  logic [15:0] score;
  logic [1:0] score_s, state, state_s;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  game_ctrl #(.HIT_FRAMES(2), .HOLD_FRAMES(3), .SCORE_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_ani_stb(stb), .i_start(start),
    .i_ob_x1(ob_x1), .i_ob_x2(ob_x2), .i_ob_y1(ob_y1), .i_ob_y2(ob_y2),
    .i_pl_x1(pl_x1), .i_pl_x2(pl_x2), .i_pl_y1(pl_y1), .i_pl_y2(pl_y2),
    .o_animate(animate), .o_obs_rst(obs_rst), .o_score(score), .o_state(state), .o_hit(hit));
  game_ctrl #(.HIT_FRAMES(2), .HOLD_FRAMES(3), .SCORE_W(2)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_ani_stb(stb), .i_start(start),
    .i_ob_x1(ob_x1), .i_ob_x2(ob_x2), .i_ob_y1(ob_y1), .i_ob_y2(ob_y2),
    .i_pl_x1(pl_x1), .i_pl_x2(pl_x2), .i_pl_y1(pl_y1), .i_pl_y2(pl_y2),
    .o_animate(animate_s), .o_obs_rst(obs_rst_s), .o_score(score_s), .o_state(state_s), .o_hit(hit_s));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic strobe();
    stb = 1'b1;
    tick();
    stb = 1'b0;
    tick();
  endtask
  task automatic set_ob(input logic [11:0] x1, input logic ov);
    ob_x1 = x1;
    ob_x2 = x1 + 12'd20;
    ob_y1 = ov ? 12'd110 : 12'd200;
    ob_y2 = ov ? 12'd130 : 12'd220;
  endtask
  task automatic restart();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rs_state", 32'(state), 1);
    chk("rs_obs_rst", 32'(obs_rst), 1);
    chk("rs_animate", 32'(animate), 0);
    chk("rs_score", 32'(score), 0);
    tick();
    chk("rs_obs_rst2", 32'(obs_rst), 0);
    chk("rs_animate2", 32'(animate), 1);
  endtask
  initial begin
    set_ob(12'd300, 1'b0);
    tick();
    tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_animate", 32'(animate), 0);
    chk("rst_obs_rst", 32'(obs_rst), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_hit", 32'(hit), 0);
    rst = 1'b0;
    tick();
    chk("idle_state", 32'(state), 0);
    restart();
    set_ob(12'd119, 1'b0);
    strobe();
    chk("sc_119", 32'(score), 0);
    set_ob(12'd120, 1'b0);
    strobe();
    chk("sc_120", 32'(score), 0);
    set_ob(12'd121, 1'b0);
    strobe();
    chk("sc_121", 32'(score), 1);
    chk("sat_1", 32'(score_s), 1);
    set_ob(12'd1, 1'b0);
    strobe();
    chk("sc_wrap", 32'(score), 1);
    for (int i = 2; i <= 5; i++) begin
      set_ob(12'd121, 1'b0);
      tick();
      chk("sc_nostb", 32'(score), i - 1);
      strobe();
      chk("sc_n", 32'(score), i);
      chk("sat_n", 32'(score_s), i > 3 ? 3 : i);
      set_ob(12'd1, 1'b0);
      strobe();
    end
    chk("sc_state", 32'(state), 1);
    set_ob(12'd110, 1'b1);
    strobe();
    chk("db_1", 32'(state), 1);
    set_ob(12'd110, 1'b0);
    strobe();
    chk("db_2", 32'(state), 1);
    set_ob(12'd110, 1'b1);
    strobe();
    chk("db_3", 32'(state), 1);
    tick();
    tick();
    chk("db_nostb", 32'(state), 1);
    stb = 1'b1;
    tick();
    stb = 1'b0;
    chk("db_4_state", 32'(state), 2);
    chk("db_4_hit", 32'(hit), 1);
    chk("db_4_animate", 32'(animate), 0);
    chk("db_4_score", 32'(score), 5);
    tick();
    strobe();
    strobe();
    chk("hold_2", 32'(state), 2);
    start = 1'b1;
    tick();
    strobe();
    chk("over_state", 32'(state), 3);
    chk("over_score", 32'(score), 5);
    chk("over_hit", 32'(hit), 0);
    chk("over_animate", 32'(animate), 0);
    tick();
    tick();
    chk("over_held_start", 32'(state), 3);
    start = 1'b0;
    tick();
    chk("over_released", 32'(state), 3);
    restart();
    set_ob(12'd121, 1'b0);
    strobe();
    chk("entry_no_score", 32'(score), 0);
    set_ob(12'd1, 1'b0);
    strobe();
    set_ob(12'd121, 1'b0);
    strobe();
    chk("rs_score1", 32'(score), 1);
    set_ob(12'd110, 1'b1);
    strobe();
    strobe();
    chk("mh_state", 32'(state), 2);
    chk("mh_hit", 32'(hit), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("hit_ign_start", 32'(state), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mh_rst_state", 32'(state), 0);
    chk("mh_rst_hit", 32'(hit), 0);
    chk("mh_rst_animate", 32'(animate), 0);
    chk("mh_rst_obs_rst", 32'(obs_rst), 0);
    chk("mh_rst_score", 32'(score), 0);
    chk("mh_rst_state_s", 32'(state_s), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/game_ctrl.md
# game_ctrl

Game-level controller that sits directly downstream of the obstacle square generator and consumes its edge outputs. It also feeds back the square's animate and reset inputs. Each animation frame it compares the obstacle box against the player box, scores obstacles the player clears, and detects collisions with a frame debounce. It sequences the game through idle, running, hit-hold and game-over states.

## Interface
- HIT_FRAMES, 2: consecutive overlapping frames required to declare a collision (1..15)
- HOLD_FRAMES, 120: frames spent in HIT before entering OVER (1..255)
- SCORE_W, 16: score counter width
- i_clk  in  1  base clock
- i_rst  in  1  reset: synchronous, active-high; one clock domain (i_clk) only
- i_ani_stb  in  1  frame strobe, one i_clk cycle wide, shared with the square generator
- i_start  in  1  start button level, already synchronized to i_clk
- i_ob_x1, i_ob_x2, i_ob_y1, i_ob_y2  in  12 each  obstacle left/right/top/bottom edges
- i_pl_x1, i_pl_x2, i_pl_y1, i_pl_y2  in  12 each  player left/right/top/bottom edges
- o_animate  out  1  drives the square's i_animate
- o_obs_rst  out  1  one-cycle pulse, drives the square's i_rst
- o_score  out  SCORE_W  obstacles cleared this game
- o_state  out  2  IDLE=0, RUN=1, HIT=2, OVER=3
- o_hit  out  1  high while in HIT

## Operation
- Start-edge detect: start_q holds i_start from the previous cycle. start_rise = i_start & ~start_q.
- IDLE: o_animate=0. On start_rise: go to RUN, clear score, hit counter and hold counter, set past_q=1, and raise o_obs_rst for the next cycle.
- RUN: o_animate = ~o_obs_rst, so animate is never high together with the obstacle reset. Everything below is evaluated only on i_ani_stb cycles.
  - overlap = (ob_x1 <= pl_x2) & (pl_x1 <= ob_x2) & (ob_y1 <= pl_y2) & (pl_y1 <= ob_y2). Comparisons are unsigned 12-bit and inclusive, so touching edges count as overlap.
  - Hit counter: increments on an overlapping strobe and clears to 0 on a non-overlapping strobe. When the incremented value equals HIT_FRAMES, go to HIT.
  - Clearance: past = (ob_x1 > pl_x2). If past & ~past_q, the score increments, saturating at all-ones. past_q <= past.
  - Obstacle wrap-around (past goes 1->0) never scores. past_q=1 on entry blocks a spurious score on the first strobe.
  - Score and collision on the same strobe: the score increments and the state still goes to HIT.
- HIT: o_animate=0, o_hit=1. The hold counter increments on each strobe; when the incremented value equals HOLD_FRAMES, go to OVER.
- OVER: o_animate=0. The score is held. On start_rise: go to RUN with the same actions as from IDLE.
- In HIT: start_rise is ignored. In RUN: start_rise is ignored.
- Score holds its value in HIT and OVER, and clears only on entry to RUN.

## Timing
- Reset values: o_state=IDLE, o_animate=0, o_obs_rst=0, o_score=0, o_hit=0. Hit counter, hold counter and start_q reset to 0; past_q resets to 1.
- i_rst has priority over every other event, in any state, including mid-RUN and mid-HIT.
- All state, counter and score updates are registered: they take effect on the clock edge after the qualifying input.
- o_obs_rst is high exactly in the first cycle that o_state=RUN, with o_animate=0 in that cycle. o_animate rises one cycle later.
- Collision latency: state becomes HIT on the edge following the HIT_FRAMES-th consecutive overlapping strobe. o_animate falls in that same cycle.
- An i_ani_stb coinciding with the o_obs_rst cycle is still evaluated, against the pre-reset obstacle edges.
- Non-strobe cycles never change the hit counter, the hold counter, past_q or the score.

## Test plan
- Reset then start: i_rst for 2 cycles, then pulse i_start high for 1 cycle.
  - Next cycle: o_state=1, o_obs_rst=1, o_animate=0, o_score=0.
  - Following cycle: o_obs_rst=0, o_animate=1.
- Debounce: in RUN with HIT_FRAMES=2, apply overlap on one strobe, no overlap on the next, then overlap on two consecutive strobes.
  - State stays RUN until the edge after the 4th strobe, then o_state=2 and o_hit=1.
- Scoring: player at x 100..120. Obstacle ob_x1 steps 119, 120, 121 on successive strobes (with overlap suppressed via y) -> o_score goes 0 to 1 after the 3rd strobe. A wrap to ob_x1=1 leaves the score at 1.
- Hold and restart with HOLD_FRAMES=3:
  - After a collision, 3 strobes -> o_state=3 with the score retained.
  - i_start held high across the transition -> no restart.
  - Release i_start, then raise it -> RUN, score 0, one o_obs_rst pulse.
- Saturation: SCORE_W=2, produce 5 clearances -> o_score stays at 3.
- Reset mid-HIT: assert i_rst while o_hit=1 -> next cycle all outputs take their reset values.
